// File: rtl/fc_engine_arbiter_if.sv
// fc_engine_arbiter_if: requester and engine handshake bundle for fc_engine_arbiter
// master: arbiter side (drives grant/rsp/eng_start/eng_sel/cap_en/status)
// slave : requesters, engine and software side (drives req, eng_done, clr_err)
interface fc_engine_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = 16
);
  localparam int SEL_W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]   req_i;
  logic [NUM_REQ-1:0]   grant_o;
  logic [NUM_REQ-1:0]   rsp_done_o;
  logic [NUM_REQ-1:0]   rsp_err_o;
  logic                 eng_start_o;
  logic                 eng_done_i;
  logic [SEL_W-1:0]     eng_sel_o;
  logic                 cap_en_o;
  logic                 busy_o;
  logic                 err_sticky_o;
  logic                 clr_err_i;
  logic [CNT_WIDTH-1:0] job_count_o;
  modport master (
    input  req_i, eng_done_i, clr_err_i,
    output grant_o, rsp_done_o, rsp_err_o, eng_start_o, eng_sel_o,
           cap_en_o, busy_o, err_sticky_o, job_count_o
  );
  modport slave (
    output req_i, eng_done_i, clr_err_i,
    input  grant_o, rsp_done_o, rsp_err_o, eng_start_o, eng_sel_o,
           cap_en_o, busy_o, err_sticky_o, job_count_o
  );
endinterface

// File: rtl/fc_engine_arbiter.sv
// fc_engine_arbiter: round-robin sequencer sharing one FC layer engine among NUM_REQ requesters
// clk   : rising-edge clock
// rst_n : asynchronous active-low reset
// bus   : requester req/grant/rsp_done/rsp_err, engine start/done/sel/cap_en,
//         status busy/err_sticky/job_count and clr_err
module fc_engine_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 16
) (
  input logic                clk,
  input logic                rst_n,
  fc_engine_arbiter_if.master bus
);
  localparam int SEL_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d, done_q, done_d, err_q, err_d;
  logic [SEL_W-1:0]     sel_q, sel_d, ptr_q, ptr_d, pick;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 start_q, start_d, sticky_q, sticky_d, found, timeout;
  // index arithmetic modulo NUM_REQ without a divider; v is always < 2*NUM_REQ
  function automatic logic [SEL_W-1:0] wrap(input int v);
    return SEL_W'(v >= NUM_REQ ? v - NUM_REQ : v);
  endfunction
  // first set request at or after the round-robin pointer, cyclically
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req_i[wrap(int'(ptr_q) + k)]) begin
        found = 1'b1;
        pick  = wrap(int'(ptr_q) + k);
      end
    end
  end
  assign timeout = timer_q == TMR_W'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    timer_d  = timer_q;
    start_d  = start_q;
    cnt_d    = cnt_q;
    done_d   = '0;
    err_d    = '0;
    sticky_d = bus.clr_err_i ? 1'b0 : sticky_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = RUN;
        grant_d = NUM_REQ'(1) << pick;
        sel_d   = pick;
        start_d = 1'b1;
        timer_d = '0;
      end
      RUN: begin
        timer_d = timer_q + 1'b1;
        // success has priority over a coincident timeout; a timeout beats clr_err
        if (bus.eng_done_i || timeout) begin
          state_d = DRAIN;
          grant_d = '0;
          start_d = 1'b0;
          done_d  = grant_q;
          if (bus.eng_done_i) cnt_d = cnt_q + 1'b1;
          else begin
            err_d    = grant_q;
            sticky_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = wrap(int'(sel_q) + 1);
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      sel_q    <= '0;
      ptr_q    <= '0;
      timer_q  <= '0;
      start_q  <= 1'b0;
      cnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      timer_q  <= timer_d;
      start_q  <= start_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  assign bus.grant_o      = grant_q;
  assign bus.rsp_done_o   = done_q;
  assign bus.rsp_err_o    = err_q;
  assign bus.eng_start_o  = start_q;
  assign bus.eng_sel_o    = sel_q;
  assign bus.cap_en_o     = bus.eng_done_i && state_q == RUN;
  assign bus.busy_o       = state_q != IDLE;
  assign bus.err_sticky_o = sticky_q;
  assign bus.job_count_o  = cnt_q;
endmodule

// File: doc/fc_engine_arbiter.md
Name: fc_engine_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one fully connected layer engine among NUM_REQ requesters (e.g. several inference lanes).
- Drives the engine's level-held start and watches its one-cycle done pulse. Returns a per-requester completion or error pulse.
- Provides the select index for an external operand/result mux and a capture strobe for the result register.
- Carries no data path.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- TIMEOUT_CYCLES, 256, maximum cycles eng_start may be held without eng_done before the job is aborted (must exceed INPUT_SIZE+3 of the engine).
- CNT_WIDTH, 16, width of the completed-job counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester job request, level; held until rsp_done.
- grant  out  NUM_REQ  one-hot grant, registered; all zero when no job is running.
- rsp_done  out  NUM_REQ  one-cycle pulse to the granted requester when its job ends (success or abort).
- rsp_err  out  NUM_REQ  one-cycle pulse coincident with rsp_done when the job was aborted by timeout.
- eng_start  out  1  start to engine, registered, held high for the whole job.
- eng_done  in  1  engine done pulse.
- eng_sel  out  $clog2(NUM_REQ)  binary index of the granted requester; operand/result mux select.
- cap_en  out  1  result capture strobe = eng_done AND state==RUN (combinational).
- busy  out  1  high in RUN and DRAIN.
- err_sticky  out  1  set on any timeout; cleared by clr_err.
- clr_err  in  1  synchronous clear of err_sticky.
- job_count  out  CNT_WIDTH  count of successfully completed jobs; wraps.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, grant=0, eng_start=0, rsp_done=0, rsp_err=0, eng_sel=0, busy=0, err_sticky=0, job_count=0, rr_ptr=0, timer=0.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - If any req bit is set, select the first set bit searching cyclically from rr_ptr upward.
  - At the next edge: grant[sel]=1, eng_sel=sel, eng_start=1, timer=0, state→RUN.
  - Latency req→grant/eng_start is 1 cycle.
- RUN:
  - eng_start stays 1; timer increments each cycle; req changes are ignored (a dropped req does not abort the job).
  - eng_done=1 is a success: at that edge eng_start=0, grant=0, rsp_done[sel]=1 for one cycle, job_count+1, state→DRAIN.
  - cap_en is high during the eng_done cycle; engine outputs are stable in that cycle.
  - timer==TIMEOUT_CYCLES-1 with eng_done=0 is an abort: eng_start=0, grant=0, rsp_done[sel]=1, rsp_err[sel]=1, err_sticky=1, job_count unchanged, state→DRAIN.
  - If eng_done and timeout coincide, success wins.
- DRAIN:
  - Exactly 1 cycle with eng_start=0, which lets the engine leave its wait-done state and return to idle.
  - rr_ptr=(sel+1) mod NUM_REQ; state→IDLE.
  - Arbitration resumes in IDLE, so minimum job-to-job spacing is job length + 2 cycles.
- Requesters must drop req in the cycle after rsp_done. A req still high in IDLE is a new job, but it is arbitrated under the rotated pointer, so a competing requester wins first.
- eng_done outside RUN is ignored: no pulse, no count, cap_en=0.
- If clr_err and a timeout occur in the same cycle, set wins.
- Reset mid-job: all outputs return immediately to reset values, eng_start drops asynchronously, and no rsp_done is issued.
- grant is always one-hot or zero; rsp_done and rsp_err are never asserted for a non-granted index.

Test Plan:
- Single requester: req=0b0001, engine model done 131 cycles after start → grant=0b0001 and eng_start 1 cycle after req; rsp_done[0] and cap_en pulse with eng_done; eng_start low 1 cycle in DRAIN; job_count=1.
- Contention: req=0b1111 held, each requester drops req after its rsp_done → grant order 0,1,2,3; four rsp_done pulses; job_count=4.
- Fairness: req[0] reasserted immediately while req[2] is pending, after job 0 → requester 2 is granted before requester 0.
- Timeout: engine never asserts done, TIMEOUT_CYCLES=256 → eng_start drops after 256 cycles high; rsp_done[sel] and rsp_err[sel] pulse together; err_sticky=1; job_count unchanged; a clr_err pulse clears err_sticky.
- Coincident eng_done and timeout on cycle 255 → success path; rsp_err=0; job_count+1.
- Reset mid-RUN (reset low for 2 cycles at cycle 50) → eng_start, grant and busy go 0 immediately, no rsp_done; after release, a held req restarts from rr_ptr=0.
- Stray eng_done in IDLE → no rsp_done, cap_en=0, job_count unchanged.
